// File: rtl/coprosit_ex_arbiter.sv
// Round-robin arbiter sharing one coprosit execution stage between NumReq requesters,
// with an in-order ID FIFO that routes each result back to the requester that issued it.

package prau_pkg;
    typedef enum logic [3:0] {
        NONE = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2,
        MUL  = 4'd3,
        DIV  = 4'd4,
        SQRT = 4'd5,
        CMP  = 4'd6
    } prau_op_e;
endpackage

module coprosit_ex_arbiter #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         tag_t          = logic
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic               [NumReq-1:0]           req_valid_i,
    output logic               [NumReq-1:0]           req_ready_o,
    input  logic               [NumReq-1:0][XLEN-1:0] req_operand_a_i,
    input  logic               [NumReq-1:0][XLEN-1:0] req_operand_b_i,
    input  prau_pkg::prau_op_e [NumReq-1:0]           req_operator_i,
    input  tag_t               [NumReq-1:0]           req_tag_i,
    output logic               [XLEN-1:0]             ex_operand_a_o,
    output logic               [XLEN-1:0]             ex_operand_b_o,
    output prau_pkg::prau_op_e                        ex_operator_o,
    output tag_t                                      ex_tag_o,
    output logic                                      ex_in_valid_o,
    input  logic                                      ex_in_ready_i,
    input  logic                                      ex_out_valid_i,
    output logic                                      ex_out_ready_o,
    input  logic               [XLEN-1:0]             ex_result_i,
    input  tag_t                                      ex_tag_i,
    output logic               [NumReq-1:0]           rsp_valid_o,
    input  logic               [NumReq-1:0]           rsp_ready_i,
    output logic               [XLEN-1:0]             rsp_result_o,
    output tag_t                                      rsp_tag_o,
    output logic                                      unexpected_rsp_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]       outstanding_o
);

    localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef logic [IdW-1:0]  id_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    id_t  rr_ptr_q, rr_ptr_d;
    logic lock_q, lock_d;
    id_t  lock_id_q, lock_id_d;
    logic unexpected_q, unexpected_d;

    id_t  id_mem_q [MaxOutstanding];
    ptr_t wr_ptr_q, rd_ptr_q;
    cnt_t count_q, count_d;

    logic fifo_full, fifo_empty, issue_en;
    id_t  rr_win, winner, head;
    logic rr_found, has_winner;
    logic in_hs, push, pop;

    // Occupancy comes from registers only, so ready never feeds back into valid.
    assign fifo_full  = (count_q == cnt_t'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);
    assign issue_en   = ~fifo_full;

    // Round-robin search upward from the pointer, wrapping modulo NumReq.
    always_comb begin
        int unsigned idx;
        id_t         cand;
        rr_win   = rr_ptr_q;
        rr_found = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            cand = id_t'(idx);
            if (!rr_found && req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    assign winner     = lock_q ? lock_id_q : rr_win;
    assign has_winner = |req_valid_i;

    // Forward the winner's payload; idle payload is all-zero with operator NONE.
    always_comb begin
        ex_in_valid_o  = issue_en & has_winner;
        ex_operand_a_o = '0;
        ex_operand_b_o = '0;
        ex_operator_o  = prau_pkg::NONE;
        ex_tag_o       = '0;
        if (has_winner) begin
            ex_operand_a_o = req_operand_a_i[winner];
            ex_operand_b_o = req_operand_b_i[winner];
            ex_operator_o  = req_operator_i[winner];
            ex_tag_o       = req_tag_i[winner];
        end
    end

    assign in_hs = ex_in_valid_o & ex_in_ready_i;
    assign push  = in_hs;

    always_comb begin
        req_ready_o         = '0;
        req_ready_o[winner] = in_hs;
    end

    // Grant lock holds a stalled winner until the execution stage accepts it.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (in_hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = (32'(winner) == NumReq - 1) ? '0 : winner + id_t'(1);
        end else if (ex_in_valid_o) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end
    end

    // Response routing by FIFO head; with nothing outstanding the response is drained.
    always_comb begin
        head           = id_mem_q[rd_ptr_q];
        rsp_valid_o    = '0;
        ex_out_ready_o = 1'b1;
        if (!fifo_empty) begin
            rsp_valid_o[head] = ex_out_valid_i;
            ex_out_ready_o    = rsp_ready_i[head];
        end
    end

    assign pop          = ex_out_valid_i & ex_out_ready_o & ~fifo_empty;
    assign unexpected_d = ex_out_valid_i & fifo_empty;
    assign rsp_result_o = ex_result_i;
    assign rsp_tag_o    = ex_tag_i;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            unexpected_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            unexpected_q <= unexpected_d;
            count_q      <= count_d;
            if (push) begin
                id_mem_q[wr_ptr_q] <= winner;
                wr_ptr_q           <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
        end
    end

    assign outstanding_o    = count_q;
    assign unexpected_rsp_o = unexpected_q;

endmodule

// File: tb/tb_coprosit_ex_arbiter.sv
// Randomized bench for coprosit_ex_arbiter against a queue-based reference model.

module tb_coprosit_ex_arbiter;
    import prau_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NumReq = 2;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned IdW    = 1;
    localparam int unsigned CntW   = 3;

    typedef logic [3:0] tb_tag_t;

    logic                              clk_i = 1'b0;
    logic                              rst_ni = 1'b0;
    logic     [NumReq-1:0]             req_valid;
    logic     [NumReq-1:0]             req_ready;
    logic     [NumReq-1:0][XLEN-1:0]   req_a;
    logic     [NumReq-1:0][XLEN-1:0]   req_b;
    prau_op_e [NumReq-1:0]             req_op;
    tb_tag_t  [NumReq-1:0]             req_tag;
    logic     [XLEN-1:0]               ex_a;
    logic     [XLEN-1:0]               ex_b;
    prau_op_e                          ex_op;
    tb_tag_t                           ex_tag;
    logic                              ex_in_valid;
    logic                              ex_in_ready;
    logic                              ex_out_valid;
    logic                              ex_out_ready;
    logic     [XLEN-1:0]               ex_result;
    tb_tag_t                           ex_rtag;
    logic     [NumReq-1:0]             rsp_valid;
    logic     [NumReq-1:0]             rsp_ready;
    logic     [XLEN-1:0]               rsp_result;
    tb_tag_t                           rsp_tag;
    logic                              unexpected;
    logic     [CntW-1:0]               outstanding;

    always #5 clk_i = ~clk_i;

    coprosit_ex_arbiter #(
        .XLEN          (XLEN),
        .NumReq        (NumReq),
        .MaxOutstanding(MaxOut),
        .tag_t         (tb_tag_t)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_operand_a_i (req_a),
        .req_operand_b_i (req_b),
        .req_operator_i  (req_op),
        .req_tag_i       (req_tag),
        .ex_operand_a_o  (ex_a),
        .ex_operand_b_o  (ex_b),
        .ex_operator_o   (ex_op),
        .ex_tag_o        (ex_tag),
        .ex_in_valid_o   (ex_in_valid),
        .ex_in_ready_i   (ex_in_ready),
        .ex_out_valid_i  (ex_out_valid),
        .ex_out_ready_o  (ex_out_ready),
        .ex_result_i     (ex_result),
        .ex_tag_i        (ex_rtag),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_tag_o       (rsp_tag),
        .unexpected_rsp_o(unexpected),
        .outstanding_o   (outstanding)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: issued requester IDs in issue order, plus arbitration state.
    int q[$];
    int m_ptr;
    bit m_lock;
    int m_lock_id;
    bit m_unexp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit chance(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    function automatic int rr_pick(input logic [NumReq-1:0] v, input int ptr);
        for (int k = 0; k < NumReq; k++) begin
            if ((v & (NumReq'(1) << ((ptr + k) % NumReq))) != '0) begin
                return (ptr + k) % NumReq;
            end
        end
        return 0;
    endfunction

    // One clock cycle: drive at posedge+1, check mid-cycle, advance the model.
    task automatic cycle(input int p_req, input int p_in, input int p_ov, input int p_rr);
        logic [IdW-1:0]    wi;
        logic [IdW-1:0]    hi;
        int                win;
        bit                issue, any, hs, e_in_valid, e_out_ready, do_pop;
        logic [NumReq-1:0] e_req_ready, e_rsp_valid;
        logic [XLEN-1:0]   e_a, e_b;
        prau_op_e          e_op;
        tb_tag_t           e_tag;

        for (int r = 0; r < NumReq; r++) begin
            if (!req_valid[r] && chance(p_req)) begin
                req_valid[r] = 1'b1;
                req_a[r]     = {$urandom, $urandom};
                req_b[r]     = {$urandom, $urandom};
                req_op[r]    = prau_op_e'(4'($urandom_range(1, 6)));
                req_tag[r]   = tb_tag_t'($urandom_range(0, 15));
            end
            rsp_ready[r] = chance(p_rr);
        end
        ex_in_ready  = chance(p_in);
        ex_out_valid = chance(p_ov);
        ex_result    = {$urandom, $urandom};
        ex_rtag      = tb_tag_t'($urandom_range(0, 15));
        #3;

        issue      = (q.size() < MaxOut);
        any        = |req_valid;
        win        = m_lock ? m_lock_id : rr_pick(req_valid, m_ptr);
        wi         = IdW'(win);
        e_in_valid = issue && any;
        e_a        = any ? req_a[wi] : '0;
        e_b        = any ? req_b[wi] : '0;
        e_op       = any ? req_op[wi] : NONE;
        e_tag      = any ? req_tag[wi] : '0;
        hs         = e_in_valid && ex_in_ready;
        e_req_ready = hs ? (NumReq'(1) << win) : '0;
        if (q.size() > 0) begin
            hi          = IdW'(q[0]);
            e_rsp_valid = ex_out_valid ? (NumReq'(1) << q[0]) : '0;
            e_out_ready = rsp_ready[hi];
        end else begin
            e_rsp_valid = '0;
            e_out_ready = 1'b1;
        end

        check("ex_in_valid", 64'(ex_in_valid), 64'(e_in_valid));
        check("req_ready", 64'(req_ready), 64'(e_req_ready));
        check("ex_operand_a", ex_a, e_a);
        check("ex_operand_b", ex_b, e_b);
        check("ex_operator", 64'(ex_op), 64'(e_op));
        check("ex_tag", 64'(ex_tag), 64'(e_tag));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
        check("ex_out_ready", 64'(ex_out_ready), 64'(e_out_ready));
        check("rsp_result", rsp_result, ex_result);
        check("rsp_tag", 64'(rsp_tag), 64'(ex_rtag));
        check("outstanding", 64'(outstanding), 64'(q.size()));
        check("unexpected_rsp", 64'(unexpected), 64'(m_unexp));

        if (rst_ni) begin
            do_pop  = (q.size() > 0) && ex_out_valid && e_out_ready;
            m_unexp = ex_out_valid && (q.size() == 0);
            if (do_pop) begin
                void'(q.pop_front());
            end
            if (hs) begin
                q.push_back(win);
                m_ptr  = (win + 1) % NumReq;
                m_lock = 1'b0;
            end else if (e_in_valid) begin
                m_lock    = 1'b1;
                m_lock_id = win;
            end
        end else begin
            hs = 1'b0;
        end

        @(posedge clk_i);
        #1;
        if (hs) begin
            req_valid[wi] = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_ni    = 1'b0;
        req_valid = '0;
        q.delete();
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        m_unexp   = 1'b0;
        repeat (cycles) cycle(0, 0, 0, 0);
        rst_ni = 1'b1;
    endtask

    initial begin
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_op       = {NumReq{NONE}};
        req_tag      = '0;
        ex_in_ready  = 1'b0;
        ex_out_valid = 1'b0;
        rsp_ready    = '0;
        ex_result    = '0;
        ex_rtag      = '0;
        #1;
        do_reset(3);

        // Steady alternation with everything ready.
        repeat (40) cycle(100, 100, 100, 100);
        // Frequent input stalls exercise the grant lock.
        repeat (300) cycle(60, 30, 60, 60);
        // No responses: FIFO fills and issue blocks.
        repeat (30) cycle(100, 100, 0, 100);
        // Slow response consumers with a full FIFO.
        repeat (60) cycle(100, 100, 50, 30);
        // Build up outstanding work, then reset in the middle of it.
        repeat (3) cycle(100, 100, 0, 100);
        do_reset(2);
        // Responses with nothing outstanding are drained and flagged.
        repeat (10) cycle(0, 0, 80, 100);
        repeat (40) cycle(100, 100, 100, 100);
        // Mixed random traffic with varying knobs.
        for (int blk = 0; blk < 80; blk++) begin
            int pr, pi, po, pk;
            pr = $urandom_range(0, 100);
            pi = $urandom_range(0, 100);
            po = $urandom_range(0, 100);
            pk = $urandom_range(0, 100);
            repeat (20) cycle(pr, pi, po, pk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
